// File: rtl/tile_writeback_dma.sv
// tile_writeback_dma
//   Store side of the tiled DMA path: scans a finished TILE_SIZE x TILE_SIZE
//   accumulator tile in row-major order, reads each in-range element through
//   the indexed tile read port, narrows it to DATA_WIDTH and writes it to DRAM
//   through a valid/ready channel. Elements outside the MxM matrix are skipped.
//
//   Build option: define TILE_WB_SATURATE_EN to narrow by signed saturation;
//   otherwise the accumulator is truncated to its low DATA_WIDTH bits.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   start                          request, accepted only while idle
//   tile_x/tile_y/dst_base/
//   matrix_size                    job config, latched on accepted start
//   tile_rd_idx/tile_rd_en         tile read request (data returns next cycle)
//   tile_rd_data                   accumulator value of the requested element
//   dram_wr_addr/data/valid/ready  DRAM write channel
//   busy, done                     job status, done is a 1-cycle pulse
module tile_writeback_dma #(
  parameter int TILE_SIZE  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  tile_x,
  input  logic [ADDR_WIDTH-1:0]                  tile_y,
  input  logic [ADDR_WIDTH-1:0]                  dst_base,
  input  logic [ADDR_WIDTH-1:0]                  matrix_size,
  output logic [$clog2(TILE_SIZE*TILE_SIZE)-1:0] tile_rd_idx,
  output logic                                   tile_rd_en,
  input  logic [ACC_WIDTH-1:0]                   tile_rd_data,
  output logic [ADDR_WIDTH-1:0]                  dram_wr_addr,
  output logic [DATA_WIDTH-1:0]                  dram_wr_data,
  output logic                                   dram_wr_valid,
  input  logic                                   dram_wr_ready,
  output logic                                   busy,
  output logic                                   done
);
  localparam int N   = TILE_SIZE * TILE_SIZE;
  localparam int IW  = $clog2(N);
  localparam int LW  = $clog2(TILE_SIZE);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [IW:0] N_CNT = (IW+1)'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] tx_q, ty_q, base_q, m_q;
  logic [IW:0]           scan_cnt;
  logic                  inflight;    // read issued last cycle, data on tile_rd_data now
  logic [ADDR_WIDTH-1:0] pend_addr;   // DRAM address of the in-flight element

  logic [ADDR_WIDTH-1:0] fifo_addr [2];
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;

  function automatic logic [DATA_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] x);
`ifdef TILE_WB_SATURATE_EN
    // In range iff every bit above the result's sign bit matches it.
    if (&x[ACC_WIDTH-1:DATA_WIDTH-1] || ~|x[ACC_WIDTH-1:DATA_WIDTH-1])
      return x[DATA_WIDTH-1:0];
    else if (x[ACC_WIDTH-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    return x[DATA_WIDTH-1:0];
`endif
  endfunction

`ifndef TILE_WB_SATURATE_EN
  logic unused_acc_hi;
  assign unused_acc_hi = ^tile_rd_data[ACC_WIDTH-1:DATA_WIDTH];
`endif

  // Range check is done one bit wider so tile origin + offset cannot wrap.
  logic [IW-1:0]         idx;
  logic [AW1-1:0]        row_abs, col_abs;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] elem_addr;
  assign idx       = scan_cnt[IW-1:0];
  assign row_abs   = {1'b0, ty_q} + AW1'(idx[IW-1:LW]);
  assign col_abs   = {1'b0, tx_q} + AW1'(idx[LW-1:0]);
  assign in_range  = (row_abs < {1'b0, m_q}) && (col_abs < {1'b0, m_q});
  assign elem_addr = base_q + row_abs[ADDR_WIDTH-1:0] * m_q + col_abs[ADDR_WIDTH-1:0];

  // Occupancy counts this cycle's pop so the scan keeps streaming at one
  // element per cycle under ready=1 while never exceeding the 2-entry FIFO.
  logic       pop, scan_go;
  logic [1:0] occ;
  assign pop     = dram_wr_valid && dram_wr_ready;
  assign occ     = fifo_count - {1'b0, pop} + {1'b0, inflight};
  assign scan_go = (state == S_RUN) && (scan_cnt != N_CNT) && !occ[1];

  assign tile_rd_en  = scan_go && in_range;
  assign tile_rd_idx = idx;

  assign dram_wr_valid = (fifo_count != 2'd0);
  assign dram_wr_addr  = fifo_addr[rd_ptr];
  assign dram_wr_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      base_q     <= '0;
      m_q        <= '0;
      scan_cnt   <= '0;
      inflight   <= 1'b0;
      pend_addr  <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      inflight <= tile_rd_en;
      if (tile_rd_en) pend_addr <= elem_addr;
      if (inflight) begin
        fifo_addr[wr_ptr] <= pend_addr;
        fifo_data[wr_ptr] <= narrow(tile_rd_data);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (scan_go) scan_cnt <= scan_cnt + 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          tx_q     <= tile_x;
          ty_q     <= tile_y;
          base_q   <= dst_base;
          m_q      <= matrix_size;
          scan_cnt <= '0;
          busy     <= 1'b1;
          state    <= S_RUN;
        end
        S_RUN: if (scan_cnt == N_CNT && !inflight && fifo_count == 2'd0) begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_writeback_dma.sv
// Directed bench for tile_writeback_dma. A queue of expected writes is built
// from the clipping/addressing/narrowing rules; a negedge process checks every
// DRAM handshake against it, plus hold-under-backpressure and no-access rules.
module tb_tile_writeback_dma;
  localparam int TS = 16;
  localparam int N  = TS * TS;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] tile_x, tile_y, dst_base, matrix_size;
  logic [7:0]  tile_rd_idx;
  logic        tile_rd_en;
  logic [31:0] tile_rd_data;
  logic [15:0] dram_wr_addr, dram_wr_data;
  logic        dram_wr_valid, dram_wr_ready, busy, done;

  tile_writeback_dma dut (
    .clk(clk), .rst(rst), .start(start),
    .tile_x(tile_x), .tile_y(tile_y), .dst_base(dst_base), .matrix_size(matrix_size),
    .tile_rd_idx(tile_rd_idx), .tile_rd_en(tile_rd_en), .tile_rd_data(tile_rd_data),
    .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_valid(dram_wr_valid), .dram_wr_ready(dram_wr_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;

  int          tests = 0, fails = 0;
  logic [31:0] src [N];
  wr_t         expq [$];
  wr_t         logq [$];
  bit          no_access = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_a, prev_d;

  // Tile source: registered read, data valid the cycle after the strobe.
  always @(posedge clk) if (tile_rd_en) tile_rd_data <= src[tile_rd_idx];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] narrow(input logic [31:0] x);
`ifdef TILE_WB_SATURATE_EN
    int v;
    v = signed'(x);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return x[15:0];
`else
    return x[15:0];
`endif
  endfunction

  task automatic build_exp(input int tx, input int ty, input int base, input int m);
    expq.delete();
    for (int r = 0; r < TS; r++)
      for (int c = 0; c < TS; c++)
        if (ty + r < m && tx + c < m)
          expq.push_back('{a: 16'(base + (ty + r) * m + (tx + c)), d: narrow(src[r*TS + c])});
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_addr", {15'b0, dram_wr_valid, dram_wr_addr}, {15'b0, 1'b1, prev_a});
        check("hold_data", {16'b0, dram_wr_data}, {16'b0, prev_d});
      end
      if (no_access) check("no_access", {30'b0, tile_rd_en, dram_wr_valid}, 32'd0);
      if (dram_wr_valid && dram_wr_ready) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", dram_wr_addr, dram_wr_data);
        end else begin
          wr_t e;
          e = expq.pop_front();
          check("wr_addr", {16'b0, dram_wr_addr}, {16'b0, e.a});
          check("wr_data", {16'b0, dram_wr_data}, {16'b0, e.d});
        end
        logq.push_back('{a: dram_wr_addr, d: dram_wr_data});
      end
      prev_stall = dram_wr_valid && !dram_wr_ready;
      prev_a = dram_wr_addr;
      prev_d = dram_wr_data;
    end
  end

  // mode 0: ready always 1; mode 1: ready toggles, with a 5-cycle low window.
  // poke: a second start with different config while busy.
  task automatic run_tile(input int tx, input int ty, input int base, input int m,
                          input int mode, input bit poke, output int cyc);
    build_exp(tx, ty, base, m);
    logq.delete();
    @(posedge clk); #1;
    tile_x = 16'(tx); tile_y = 16'(ty); dst_base = 16'(base); matrix_size = 16'(m);
    start = 1'b1; dram_wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 10) begin
        start = 1'b1; tile_x = 16'h40; tile_y = 16'h40; dst_base = 16'hdead; matrix_size = 16'd3;
      end else if (poke && cyc == 11) start = 1'b0;
      if (mode == 1) dram_wr_ready = (cyc >= 60 && cyc < 65) ? 1'b0 : (cyc % 2 == 0);
      if (done) break;
      if (cyc >= 3000) begin
        tests++; fails++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
    end
    dram_wr_ready = 1'b1;
    check("exp_drained", expq.size(), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_clear", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; tile_x = '0; tile_y = '0; dst_base = '0; matrix_size = '0;
    dram_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", {23'b0, tile_rd_en, tile_rd_idx}, 32'd0);
    check("rst_wr", {dram_wr_addr, dram_wr_data}, 32'd0);
    check("rst_ctl", {29'b0, dram_wr_valid, busy, done}, 32'd0);
    rst = 1'b0;

    // 1: full tile, ready=1
    for (int i = 0; i < N; i++) src[i] = 32'(i);
    run_tile(0, 0, 'h100, 64, 0, 0, cyc);
    check("t1_latency", cyc, 32'd259);
    check("t1_count", logq.size(), 32'd256);
    check("t1_first_addr", {16'b0, logq[0].a}, 32'h100);
    check("t1_last_addr", {16'b0, logq[255].a}, 32'h4cf);
    check("t1_last_data", {16'b0, logq[255].d}, 32'hff);

    // 2: edge tile clipped to 4x4
    for (int i = 0; i < N; i++) src[i] = 32'(i * 3 + 7);
    run_tile(16, 16, 0, 20, 0, 0, cyc);
    check("t2_count", logq.size(), 32'd16);
    check("t2_first_addr", {16'b0, logq[0].a}, 32'd336);
    check("t2_last_addr", {16'b0, logq[15].a}, 32'd399);
    check("t2_first_data", {16'b0, logq[0].d}, 32'd7);
    check("t2_last_data", {16'b0, logq[15].d}, 32'd160);

    // 3: backpressure plus an ignored start while busy
    for (int i = 0; i < N; i++) src[i] = 32'habcd0000 + 32'(i);
    run_tile(0, 0, 'h2000, 16, 1, 1, cyc);
    check("t3_count", logq.size(), 32'd256);
    check("t3_slowed", {31'b0, cyc > 259}, 32'd1);
    check("t3_addr17", {16'b0, logq[17].a}, 32'h2011);
    check("t3_data17", {16'b0, logq[17].d}, 32'h0011);

    // 4: reset mid-tile, then a fresh tile from idx 0
    for (int i = 0; i < N; i++) src[i] = 32'(i);
    build_exp(0, 0, 0, 16);
    @(posedge clk); #1;
    tile_x = 0; tile_y = 0; dst_base = 0; matrix_size = 16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("t4_rst_rd", {23'b0, tile_rd_en, tile_rd_idx}, 32'd0);
    check("t4_rst_wr", {dram_wr_addr, dram_wr_data}, 32'd0);
    check("t4_rst_ctl", {29'b0, dram_wr_valid, busy, done}, 32'd0);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_tile(0, 0, 0, 16, 0, 0, cyc);
    check("t4_latency", cyc, 32'd259);
    check("t4_first_addr", {16'b0, logq[0].a}, 32'd0);
    check("t4_count", logq.size(), 32'd256);

    // 5: narrowing
    for (int i = 0; i < N; i++) src[i] = '0;
    src[0] = 32'h00012345;
    src[1] = 32'hffff8000;
    run_tile(0, 0, 0, 2, 0, 0, cyc);
    check("t5_count", logq.size(), 32'd4);
`ifdef TILE_WB_SATURATE_EN
    check("t5_pos", {16'b0, logq[0].d}, 32'h7fff);
`else
    check("t5_pos", {16'b0, logq[0].d}, 32'h2345);
`endif
    check("t5_neg", {16'b0, logq[1].d}, 32'h8000);

    // address wrap modulo 2^16
    run_tile(0, 0, 'hfffe, 4, 0, 0, cyc);
    check("wrap_addr2", {16'b0, logq[2].a}, 32'h0000);

    // 6: M=0 and a tile fully outside the matrix
    no_access = 1'b1;
    run_tile(0, 0, 0, 0, 0, 0, cyc);
    check("t6_latency", cyc, 32'd257);
    check("t6_count", logq.size(), 32'd0);
    run_tile(100, 0, 0, 20, 0, 0, cyc);
    check("outside_latency", cyc, 32'd257);
    no_access = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
